mem_arbiter: RTL and testbench

Two-port memory arbiter that shares the single memory/IO slave port between the processor's instruction-fetch port (read-only) and its load/store data port. It sits between `Processor` and the memory/peripheral decode logic. It grants one request at a time, using round-robin when both ports request together. Each transaction is run through a request/ready handshake with the slave. A watchdog terminates any access the slave never acknowledges.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and shared slave port.
// The master modport is the arbiter's view (it owns the shared slave port).
// The slave modport is the environment's view (processor ports plus memory).
interface mem_arbiter_if;
  // instruction-fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  // load/store port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  // shared memory/IO slave port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_ack, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_rdata, d_ack, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_ack, i_err,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_rdata, d_ack, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory/IO slave port between the
// instruction-fetch port (read-only) and the load/store port. One transaction
// at a time, round-robin on contention, watchdog-terminated if the slave
// never answers. All outputs are registered.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        stateR;
  logic          lastR;     // 1 = data port was granted last
  logic          gntDataR;  // 1 = current transaction belongs to the data port
  logic [CW-1:0] cntR;      // BUSY cycles spent waiting for mem_ready

  logic          pickDataS;
  logic          doneS;
  logic [31:0]   respDataS;
  logic          respErrS;

  // Grant choice: data wins when alone, or on contention when fetch went last.
  always_comb begin
    pickDataS = bus.d_req & (~bus.i_req | ~lastR);
  end

  // Completion decode in BUSY: slave answer or watchdog expiry.
  always_comb begin
    doneS     = 1'b0;
    respDataS = 32'h0000_0000;
    respErrS  = 1'b0;
    if (bus.mem_ready) begin
      doneS     = 1'b1;
      respDataS = bus.mem_we ? 32'h0000_0000 : bus.mem_rdata;
      respErrS  = 1'b0;
    end else if (cntR == CW'(TIMEOUT - 1)) begin
      doneS     = 1'b1;
      respDataS = 32'h0000_0000;
      respErrS  = 1'b1;
    end else begin
      doneS     = 1'b0;
      respDataS = 32'h0000_0000;
      respErrS  = 1'b0;
    end
  end

  // Arbitration FSM with registered slave-side and port-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR        <= IDLE;
      lastR         <= 1'b1;
      gntDataR      <= 1'b0;
      cntR          <= {CW{1'b0}};
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0000_0000;
      bus.mem_wdata <= 32'h0000_0000;
      bus.mem_wmask <= 4'b0000;
      bus.i_ack     <= 1'b0;
      bus.i_err     <= 1'b0;
      bus.i_rdata   <= 32'h0000_0000;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= 32'h0000_0000;
    end else begin
      // acks are single-cycle pulses; only the BUSY->RESP step raises one
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (stateR)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            gntDataR    <= pickDataS;
            lastR       <= pickDataS;
            cntR        <= {CW{1'b0}};
            bus.mem_req <= 1'b1;
            stateR      <= BUSY;
            if (pickDataS) begin
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_wmask <= bus.d_we ? bus.d_wmask : 4'b0000;
            end else begin
              // fetches are always reads with no byte enables
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.i_addr;
              bus.mem_wdata <= 32'h0000_0000;
              bus.mem_wmask <= 4'b0000;
            end
          end else begin
            stateR <= IDLE;
          end
        end
        BUSY: begin
          if (doneS) begin
            bus.mem_req <= 1'b0;
            stateR      <= RESP;
            if (gntDataR) begin
              bus.d_rdata <= respDataS;
              bus.d_err   <= respErrS;
              bus.d_ack   <= 1'b1;
            end else begin
              bus.i_rdata <= respDataS;
              bus.i_err   <= respErrS;
              bus.i_ack   <= 1'b1;
            end
          end else begin
            cntR <= cntR + CW'(1);
          end
        end
        RESP: begin
          stateR <= IDLE;
        end
        default: begin
          stateR      <= IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand-written contention, round-robin and mid-transaction reset sequences.
// Expected results are queued in grant order and compared on each ack.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isData;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          waitC;      // slave wait cycles before mem_ready
    logic [31:0] slaveData;  // value the slave returns
    logic [31:0] expRdata;
    logic        expErr;
    int          expBusy;    // expected cycles with mem_req high
  } vec_t;

  vec_t        tbl[8];
  vec_t        sb[$];
  int          nChecks = 0;
  int          nErrors = 0;
  logic [31:0] iRdM, dRdM;
  logic        iErrM, dErrM;
  int          iHold, dHold;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic idleInputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;
    bus.d_wmask   = 4'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    iHold = 0;
    dHold = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    iRdM = 32'h0; dRdM = 32'h0; iErrM = 1'b0; dErrM = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    chk({tag, "_mem_req"},   {31'h0, bus.mem_req}, 32'h0);
    chk({tag, "_mem_we"},    {31'h0, bus.mem_we}, 32'h0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_mem_wmask"}, {28'h0, bus.mem_wmask}, 32'h0);
    chk({tag, "_i_ack"},     {31'h0, bus.i_ack}, 32'h0);
    chk({tag, "_d_ack"},     {31'h0, bus.d_ack}, 32'h0);
    chk({tag, "_i_err"},     {31'h0, bus.i_err}, 32'h0);
    chk({tag, "_d_err"},     {31'h0, bus.d_err}, 32'h0);
    chk({tag, "_i_rdata"},   bus.i_rdata, 32'h0);
    chk({tag, "_d_rdata"},   bus.d_rdata, 32'h0);
  endtask

  // Raise an idle port with its next queued transaction once it has been
  // low through the IDLE cycle that follows its previous ack.
  task automatic raisePorts();
    if (!bus.i_req) begin
      if (iHold > 0) iHold--;
      else begin
        for (int k = 0; k < sb.size(); k++) begin
          if (!sb[k].isData) begin
            bus.i_req  = 1'b1;
            bus.i_addr = sb[k].addr;
            break;
          end
        end
      end
    end
    if (!bus.d_req) begin
      if (dHold > 0) dHold--;
      else begin
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].isData) begin
            bus.d_req   = 1'b1;
            bus.d_we    = sb[k].we;
            bus.d_addr  = sb[k].addr;
            bus.d_wdata = sb[k].wdata;
            bus.d_wmask = sb[k].wmask;
            break;
          end
        end
      end
    end
  endtask

  // Drive queued transactions, play the slave, and score every ack.
  task automatic runScenario(input int budget);
    int   busy;
    int   cyc;
    logic prevAck;
    logic isStore;
    vec_t e;
    busy    = 0;
    cyc     = 0;
    prevAck = 1'b0;
    repeat (2) @(negedge clk);
    iHold = 0;
    dHold = 0;
    raisePorts();
    while (sb.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.i_ack || bus.d_ack) begin
        e = sb.pop_front();
        chk("ack_single_cycle", {31'h0, prevAck}, 32'h0);
        chk("ack_i_port", {31'h0, bus.i_ack}, {31'h0, ~e.isData});
        chk("ack_d_port", {31'h0, bus.d_ack}, {31'h0, e.isData});
        chk("busy_cycles", busy, e.expBusy);
        if (e.isData) begin
          chk("d_rdata", bus.d_rdata, e.expRdata);
          chk("d_err", {31'h0, bus.d_err}, {31'h0, e.expErr});
          chk("i_rdata_hold", bus.i_rdata, iRdM);
          chk("i_err_hold", {31'h0, bus.i_err}, {31'h0, iErrM});
          dRdM = e.expRdata; dErrM = e.expErr;
          bus.d_req = 1'b0;
          dHold = 2;
        end else begin
          chk("i_rdata", bus.i_rdata, e.expRdata);
          chk("i_err", {31'h0, bus.i_err}, {31'h0, e.expErr});
          chk("d_rdata_hold", bus.d_rdata, dRdM);
          chk("d_err_hold", {31'h0, bus.d_err}, {31'h0, dErrM});
          iRdM = e.expRdata; iErrM = e.expErr;
          bus.i_req = 1'b0;
          iHold = 2;
        end
        busy = 0;
      end
      prevAck = bus.i_ack | bus.d_ack;
      if (bus.mem_req && sb.size() > 0) begin
        busy++;
        e = sb[0];
        isStore = e.isData & e.we;
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_we", {31'h0, bus.mem_we}, {31'h0, isStore});
        chk("mem_wmask", {28'h0, bus.mem_wmask}, isStore ? {28'h0, e.wmask} : 32'h0);
        if (isStore) chk("mem_wdata", bus.mem_wdata, e.wdata);
        bus.mem_ready = (busy == e.waitC + 1);
        bus.mem_rdata = e.slaveData;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom();
      end
      raisePorts();
    end
    if (sb.size() > 0) begin
      nChecks++;
      nErrors++;
      $display("FAIL scenario_budget: %0d transactions still outstanding", sb.size());
      sb.delete();
    end
    bus.mem_ready = 1'b0;
  endtask

  // Load/fetch held in BUSY, then reset pulsed while the slave stays silent.
  task automatic resetMidOp();
    int busy;
    busy = 0;
    repeat (2) @(negedge clk);
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0000_0800;
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 10 && busy < 3; c++) begin
      @(negedge clk);
      if (bus.mem_req) busy++;
    end
    chk("midop_busy_reached", busy, 3);
    reset     = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checkIdleOutputs("midop_reset");
    @(negedge clk);
    chk("midop_still_idle_req", {31'h0, bus.mem_req}, 32'h0);
    chk("midop_no_ack", {30'h0, bus.i_ack, bus.d_ack}, 32'h0);
    iRdM = 32'h0; dRdM = 32'h0; iErrM = 1'b0; dErrM = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          isData we    addr           wdata          wmask    wait   slaveData      expRdata       err   busy
    tbl[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 0,     32'h0000_0013, 32'h0000_0013, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b1, 32'h0040_0004, 32'hDEAD_BEEF, 4'b0011, 3,     32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 4};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_2000, 32'h1234_0000, 4'b1111, NEVER, 32'h0000_5555, 32'h0000_0000, 1'b1, TIMEOUT};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0000_0000, 4'b0000, 0,     32'h0010_0093, 32'h0010_0093, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0000_0000, 4'b0000, 14,    32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, TIMEOUT};
    tbl[5] = '{1'b0, 1'b0, 32'h0000_0018, 32'h0000_0000, 4'b0000, 13,    32'h1234_5678, 32'h1234_5678, 1'b0, 14};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 4'b0000, 0,     32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_0008, 32'h7700_0000, 4'b1000, 1,     32'h0BAD_0BAD, 32'h0000_0000, 1'b0, 2};

    doReset();
    checkIdleOutputs("reset");

    for (int i = 0; i < 8; i++) begin
      sb.push_back(tbl[i]);
      runScenario(60);
    end

    // both ports held from reset: fetch, data, fetch, data
    doReset();
    sb.push_back('{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h1111_1111, 32'h1111_1111, 1'b0, 1});
    sb.push_back('{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1, 32'h2222_2222, 32'h2222_2222, 1'b0, 2});
    sb.push_back('{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 32'h3333_3333, 32'h3333_3333, 1'b0, 1});
    sb.push_back('{1'b1, 1'b1, 32'h0000_0204, 32'h4444_4444, 4'hF, 0, 32'h9999_9999, 32'h0000_0000, 1'b0, 1});
    runScenario(80);

    // after a lone fetch, simultaneous requests go to data first
    sb.push_back('{1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 0, 32'h5555_0001, 32'h5555_0001, 1'b0, 1});
    runScenario(40);
    sb.push_back('{1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 2, 32'h6666_0002, 32'h6666_0002, 1'b0, 3});
    sb.push_back('{1'b0, 1'b0, 32'h0000_010C, 32'h0, 4'h0, 0, 32'h7777_0003, 32'h7777_0003, 1'b0, 1});
    runScenario(60);

    // reset during BUSY; afterwards fetch wins contention and completes in 2 cycles
    resetMidOp();
    sb.push_back('{1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 32'h8888_0004, 32'h8888_0004, 1'b0, 1});
    sb.push_back('{1'b1, 1'b0, 32'h0000_0024, 32'h0, 4'h0, 0, 32'h9999_0005, 32'h9999_0005, 1'b0, 1});
    runScenario(60);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
